// File: rtl/buzzer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_arbiter
// Purpose  : Shares the single board buzzer among three alert requesters
//            (info, warning, alarm) by fixed priority, then plays a
//            per-requester beep pattern.
//            A pattern is BEEPSi beeps. Each beep lasts ON_TICKS tick edges.
//            Beeps are separated by OFF_TICKS edges. GAP_TICKS silent edges
//            follow the last beep before the next grant.
// Ports    : i_clk        system clock
//            i_rst_n      asynchronous active-low reset
//            i_tick       slow square wave; every rising edge is one tick
//            i_tone500    500 Hz tone square (requester 0, info)
//            i_tone1k     1 kHz tone square  (requester 1, warning)
//            i_tone2k     2 kHz tone square  (requester 2, alarm)
//            i_req[2:0]   one-cycle request pulses, bit2 highest priority
//            o_buzzer     gated tone, registered
//            o_busy       high whenever a pattern is in progress
//            o_active_id  granted requester 0..2, 3 when idle
//            o_done       one-cycle pulse when a pattern finishes its gap
//            o_done_id    requester whose pattern finished, valid with o_done
// Options  : BUZZER_PREEMPT_EN - when defined, a pending higher-priority
//            request aborts the running pattern. The aborted requester is
//            re-queued and no Done pulse is issued for it.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_arbiter #(
  parameter int ON_TICKS  = 10,
  parameter int OFF_TICKS = 10,
  parameter int GAP_TICKS = 30,
  parameter int BEEPS0    = 1,
  parameter int BEEPS1    = 2,
  parameter int BEEPS2    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_tone500,
  input  logic       i_tone1k,
  input  logic       i_tone2k,
  input  logic [2:0] i_req,
  output logic       o_buzzer,
  output logic       o_busy,
  output logic [1:0] o_active_id,
  output logic       o_done,
  output logic [1:0] o_done_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Terminal values of the tick counter: the phase ends on the edge that
  // arrives while the counter already holds N-1.
  localparam logic [7:0] C_ON_LAST  = 8'(ON_TICKS - 1);
  localparam logic [7:0] C_OFF_LAST = 8'(OFF_TICKS - 1);
  localparam logic [7:0] C_GAP_LAST = 8'(GAP_TICKS - 1);
  localparam logic [1:0] C_ID_IDLE  = 2'd3;

  state_t     r_state;
  logic       r_tick_q;
  logic [2:0] r_pending;
  logic [7:0] r_tick_cnt;
  logic [2:0] r_beep_cnt;
  logic [1:0] r_active_id;
  logic       r_buzzer;
  logic       r_done;
  logic [1:0] r_done_id;

  logic       w_tick_p;
  logic       w_grant_vld;
  logic [1:0] w_grant_id;
  logic [2:0] w_grant_mask;
  logic [2:0] w_active_mask;
  logic [2:0] w_grant_beeps;
  logic       w_sel_tone;
  logic       w_preempt;

  assign w_tick_p = i_tick & ~r_tick_q;

  // Fixed priority: the highest pending bit wins.
  assign w_grant_vld = (r_state == ST_IDLE) && (r_pending != 3'b000);

  always_comb begin
    w_grant_id = 2'd0;
    if (r_pending[2]) begin
      w_grant_id = 2'd2;
    end else if (r_pending[1]) begin
      w_grant_id = 2'd1;
    end
  end

  assign w_grant_mask  = w_grant_vld ? 3'(3'b001 << w_grant_id) : 3'b000;
  // This expression is zero for the idle id 3, because the 1 shifts out of the 3-bit field.
  assign w_active_mask = 3'(3'b001 << r_active_id);

  always_comb begin
    w_grant_beeps = 3'(BEEPS0);
    w_sel_tone    = 1'b0;
    case (w_grant_id)
      2'd1:    w_grant_beeps = 3'(BEEPS1);
      2'd2:    w_grant_beeps = 3'(BEEPS2);
      default: w_grant_beeps = 3'(BEEPS0);
    endcase
    case (r_active_id)
      2'd0:    w_sel_tone = i_tone500;
      2'd1:    w_sel_tone = i_tone1k;
      2'd2:    w_sel_tone = i_tone2k;
      default: w_sel_tone = 1'b0;
    endcase
  end

`ifdef BUZZER_PREEMPT_EN
  // A pending bit above the active requester aborts the running pattern.
  always_comb begin
    w_preempt = 1'b0;
    if (r_state != ST_IDLE) begin
      case (r_active_id)
        2'd0:    w_preempt = r_pending[2] | r_pending[1];
        2'd1:    w_preempt = r_pending[2];
        default: w_preempt = 1'b0;
      endcase
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  // Tick edge detector. It resets to 1, so a tick that is already high at reset release does not produce an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_q <= 1'b1;
    end else begin
      r_tick_q <= i_tick;
    end
  end

  // A new request takes priority over the clear caused by a grant. An aborted requester is re-queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 3'b000;
    end else begin
      r_pending <= (r_pending & ~w_grant_mask) | i_req |
                   (w_preempt ? w_active_mask : 3'b000);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= 8'd0;
      r_beep_cnt  <= 3'd0;
      r_active_id <= C_ID_IDLE;
      r_buzzer    <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= 2'd0;
    end else begin
      r_done   <= 1'b0;
      r_buzzer <= (r_state == ST_ON) ? w_sel_tone : 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Tick edges that arrive while idle are not counted.
          if (w_grant_vld) begin
            r_state     <= ST_ON;
            r_active_id <= w_grant_id;
            r_beep_cnt  <= w_grant_beeps;
            r_tick_cnt  <= 8'd0;
          end
        end
        default: begin
          if (w_preempt) begin
            r_state     <= ST_IDLE;
            r_active_id <= C_ID_IDLE;
            r_tick_cnt  <= 8'd0;
            r_beep_cnt  <= 3'd0;
          end else if (w_tick_p) begin
            case (r_state)
              ST_ON: begin
                if (r_tick_cnt == C_ON_LAST) begin
                  r_tick_cnt <= 8'd0;
                  r_beep_cnt <= r_beep_cnt - 3'd1;
                  r_state    <= (r_beep_cnt == 3'd1) ? ST_GAP : ST_OFF;
                end else begin
                  r_tick_cnt <= r_tick_cnt + 8'd1;
                end
              end
              ST_OFF: begin
                if (r_tick_cnt == C_OFF_LAST) begin
                  r_tick_cnt <= 8'd0;
                  r_state    <= ST_ON;
                end else begin
                  r_tick_cnt <= r_tick_cnt + 8'd1;
                end
              end
              default: begin
                if (r_tick_cnt == C_GAP_LAST) begin
                  r_tick_cnt  <= 8'd0;
                  r_state     <= ST_IDLE;
                  r_done      <= 1'b1;
                  r_done_id   <= r_active_id;
                  r_active_id <= C_ID_IDLE;
                end else begin
                  r_tick_cnt <= r_tick_cnt + 8'd1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign o_buzzer    = r_buzzer;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_active_id = r_active_id;
  assign o_done      = r_done;
  assign o_done_id   = r_done_id;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_buzzer_arbiter
// Purpose  : Self-checking bench for buzzer_arbiter. The reference model
//            tracks each pattern as "tick edges consumed so far". It derives
//            the beep on/off shape arithmetically from that count and from
//            the pattern length.
// Options  : BUZZER_PREEMPT_EN selects the preemptive expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_arbiter;

  localparam int ON_T  = 2;
  localparam int OFF_T = 1;
  localparam int GAP_T = 3;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       tone500;
  logic       tone1k;
  logic       tone2k;
  logic [2:0] req;
  logic       o_buzzer;
  logic       o_busy;
  logic [1:0] o_active_id;
  logic       o_done;
  logic [1:0] o_done_id;

  buzzer_arbiter #(
    .ON_TICKS (ON_T),
    .OFF_TICKS(OFF_T),
    .GAP_TICKS(GAP_T),
    .BEEPS0   (1),
    .BEEPS1   (2),
    .BEEPS2   (3)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tick     (tick),
    .i_tone500  (tone500),
    .i_tone1k   (tone1k),
    .i_tone2k   (tone2k),
    .i_req      (req),
    .o_buzzer   (o_buzzer),
    .o_busy     (o_busy),
    .o_active_id(o_active_id),
    .o_done     (o_done),
    .o_done_id  (o_done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  bit         m_busy;
  int         m_id;
  int         m_k;       // tick edges consumed by the current pattern
  logic [2:0] m_pend;
  bit         m_done;
  int         m_done_id;
  bit         m_buz;
  bit         m_tickq;
  int         tphase;
  int         done_log[$];

  function automatic int beeps_of(input int id);
    return (id == 0) ? 1 : ((id == 1) ? 2 : 3);
  endfunction

  function automatic int total_of(input int id);
    return beeps_of(id) * ON_T + (beeps_of(id) - 1) * OFF_T + GAP_T;
  endfunction

  // Beeps occupy the first ON_T edges of every (ON_T+OFF_T) period until the last beep ends.
  function automatic bit in_on(input int id, input int k);
    int last_on_end;
    last_on_end = beeps_of(id) * ON_T + (beeps_of(id) - 1) * OFF_T;
    return (k < last_on_end) && ((k % (ON_T + OFF_T)) < ON_T);
  endfunction

  function automatic bit tone_of(input int id);
    return (id == 0) ? tone500 : ((id == 1) ? tone1k : tone2k);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_id = 3; m_k = 0; m_pend = 3'b000;
    m_done = 0; m_done_id = 0; m_buz = 0; m_tickq = 1;
  endtask

  // Advance the model by one clock, using the input values sampled at that edge.
  task automatic model_clock();
    bit tp;
    bit nbuz;
    bit abort;
    int g;
    tp   = tick & ~m_tickq;
    nbuz = (m_busy && in_on(m_id, m_k)) ? tone_of(m_id) : 1'b0;
    m_done = 0;
    abort  = 0;
    if (!m_busy) begin
      if (m_pend != 3'b000) begin
        g = m_pend[2] ? 2 : (m_pend[1] ? 1 : 0);
        m_pend = (m_pend & ~(3'(3'b001 << g))) | req;
        m_busy = 1; m_id = g; m_k = 0;
      end else begin
        m_pend = m_pend | req;
      end
    end else begin
`ifdef BUZZER_PREEMPT_EN
      for (int j = m_id + 1; j < 3; j++) if (m_pend[j]) abort = 1;
`endif
      if (abort) begin
        m_pend = m_pend | req | 3'(3'b001 << m_id);
        m_busy = 0; m_id = 3; m_k = 0;
      end else begin
        m_pend = m_pend | req;
        if (tp) begin
          m_k++;
          if (m_k == total_of(m_id)) begin
            m_busy = 0; m_done = 1; m_done_id = m_id; m_id = 3; m_k = 0;
          end
        end
      end
    end
    m_buz   = nbuz;
    m_tickq = tick;
  endtask

  // One clock: drive inputs, let the edge happen, update the model, and compare the outputs 1 time unit after the edge.
  task automatic step(input logic [2:0] r);
    tphase  = (tphase + 1) % 20;
    tick    = (tphase < 10);
    tone500 = 1'($urandom);
    tone1k  = 1'($urandom);
    tone2k  = 1'($urandom);
    req     = r;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_clock();
    #1;
    check_val("cycle", {25'd0, o_buzzer, o_busy, o_active_id, o_done, o_done_id},
              {25'd0, m_buz, m_busy, 2'(m_id), m_done, 2'(m_done_id)});
    if (o_done) done_log.push_back(int'(o_done_id));
    req = 3'b000;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      step(3'b000);
      n++;
    end while ((m_busy || m_pend != 3'b000 || o_busy) && n < budget);
    if (n >= budget) check_val("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 0; tick = 0; tone500 = 0; tone1k = 0; tone2k = 0; req = 3'b000;
    tphase = 0;
    model_reset();

    // Hold reset with requests and a toggling tick.
    repeat (25) step(3'b111);
    check_val("rst_buzzer", {31'd0, o_buzzer}, 32'd0);
    check_val("rst_busy",   {31'd0, o_busy},   32'd0);
    check_val("rst_id",     {30'd0, o_active_id}, 32'd3);
    check_val("rst_done",   {31'd0, o_done},   32'd0);
    // Release the reset while the tick is high.
    while (tphase != 5) step(3'b000);
    rst_n = 1;
    repeat (3) step(3'b000);
    check_val("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // Single info request: the grant appears two cycles after the request pulse.
    done_log.delete();
    step(3'b001);
    check_val("info_lat1", {31'd0, o_busy}, 32'd0);
    step(3'b000);
    check_val("info_lat2", {31'd0, o_busy}, 32'd1);
    check_val("info_id", {30'd0, o_active_id}, 32'd0);
    wait_idle(2000);
    check_val("info_ndone", done_log.size(), 32'd1);
    if (done_log.size() == 1) check_val("info_doneid", done_log[0], 32'd0);

    // Alarm pattern: the pattern spans 11 tick edges, so it must finish in 11 tick periods plus a partial period.
    begin
      int cyc;
      done_log.delete();
      step(3'b100);
      cyc = 0;
      while (done_log.size() == 0 && cyc < 400) begin
        step(3'b000);
        cyc++;
      end
      check_val("alarm_doneid", (done_log.size() > 0) ? done_log[0] : 99, 32'd2);
      check_val("alarm_len", (cyc > 200 && cyc <= 222) ? 1 : 0, 32'd1);
      wait_idle(2000);
    end

    // Priority order, with all three requests raised in the same cycle.
    done_log.delete();
    step(3'b111);
    wait_idle(3000);
    check_val("prio_n", done_log.size(), 32'd3);
    if (done_log.size() == 3) begin
      check_val("prio_0", done_log[0], 32'd2);
      check_val("prio_1", done_log[1], 32'd1);
      check_val("prio_2", done_log[2], 32'd0);
    end

    // Merge and replay of the warning pattern.
    done_log.delete();
    step(3'b010);
    repeat (3) begin
      repeat (30) step(3'b000);
      step(3'b010);
    end
    wait_idle(3000);
    check_val("merge_n", done_log.size(), 32'd2);
    foreach (done_log[i]) check_val("merge_id", done_log[i], 32'd1);

    // Alarm request that arrives during an info beep.
    done_log.delete();
    step(3'b001);
    repeat (8) step(3'b000);
    step(3'b100);
    wait_idle(3000);
    check_val("pre_n", done_log.size(), 32'd2);
    if (done_log.size() == 2) begin
`ifdef BUZZER_PREEMPT_EN
      check_val("pre_first", done_log[0], 32'd2);
      check_val("pre_second", done_log[1], 32'd0);
`else
      check_val("pre_first", done_log[0], 32'd0);
      check_val("pre_second", done_log[1], 32'd2);
`endif
    end

    // Random request traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 24) == 0) step(3'($urandom_range(1, 7)));
      else                            step(3'b000);
    end
    wait_idle(5000);

    // Asynchronous reset in the middle of a pattern: all pending requests are lost.
    done_log.delete();
    step(3'b110);
    repeat (40) step(3'b000);
    #2 rst_n = 0;
    #1;
    check_val("arst_busy",   {31'd0, o_busy},   32'd0);
    check_val("arst_id",     {30'd0, o_active_id}, 32'd3);
    check_val("arst_buzzer", {31'd0, o_buzzer}, 32'd0);
    model_reset();
    repeat (3) step(3'b000);
    rst_n = 1;
    repeat (100) step(3'b000);
    check_val("arst_lost", done_log.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
